// File: rtl/rib_pkg.sv
// Shared RIB definitions: master indices, FSM encoding and the per-master request bundle.
package rib_pkg;

  localparam int RIB_AW = 32;
  localparam int RIB_DW = 32;

  localparam logic [1:0] RIB_M_JTAG = 2'd0;
  localparam logic [1:0] RIB_M_CORE = 2'd1;
  localparam logic [1:0] RIB_M_UART = 2'd2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic              wr_en;
    logic [RIB_AW-1:0] addr;
    logic [RIB_DW-1:0] data;
  } rib_req_t;

endpackage

// File: rtl/rib_prio_enc.sv
// Fixed-priority encoder over the three RIB masters; bit 0 (JTAG) wins.
module rib_prio_enc
  import rib_pkg::*;
(
  input  logic [2:0] req,
  output logic [1:0] idx,
  output logic       any
);

  always_comb begin
    idx = RIB_M_JTAG;
    if (req[0])      idx = RIB_M_JTAG;
    else if (req[1]) idx = RIB_M_CORE;
    else if (req[2]) idx = RIB_M_UART;
  end

  assign any = |req;

endmodule

// File: rtl/rib_arbiter.sv
// RIB bus arbiter: three masters share one slave port through an IDLE/BUSY
// handshake sequencer with a per-transaction timeout.
module rib_arbiter
  import rib_pkg::*;
#(
  parameter int                TIMEOUT  = 16,
  parameter logic [RIB_DW-1:0] ERR_DATA = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic              m0_wr_en_i,
  input  logic [RIB_AW-1:0] m0_addr_i,
  input  logic [RIB_DW-1:0] m0_data_i,
  output logic [RIB_DW-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_req_i,
  input  logic              m1_wr_en_i,
  input  logic [RIB_AW-1:0] m1_addr_i,
  input  logic [RIB_DW-1:0] m1_data_i,
  output logic [RIB_DW-1:0] m1_data_o,
  output logic              m1_ack_o,
  input  logic              m2_req_i,
  input  logic              m2_wr_en_i,
  input  logic [RIB_AW-1:0] m2_addr_i,
  input  logic [RIB_DW-1:0] m2_data_i,
  output logic [RIB_DW-1:0] m2_data_o,
  output logic              m2_ack_o,
  output logic              s_req_o,
  output logic              s_wr_en_o,
  output logic [RIB_AW-1:0] s_addr_o,
  output logic [RIB_DW-1:0] s_data_o,
  input  logic [RIB_DW-1:0] s_data_i,
  input  logic              s_ack_i,
  output logic              hold_o,
  output logic              err_o
);

  localparam int             CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  logic [0:0]        state;
  logic [1:0]        grant;
  logic [CW-1:0]     cnt;
  logic [1:0]        enc_idx;
  logic              enc_any;
  logic              busy;
  logic              done;
  rib_req_t          sel;
  logic [RIB_DW-1:0] rdata;

  rib_prio_enc u_enc (
    .req ({m2_req_i, m1_req_i, m0_req_i}),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      grant <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (enc_any) begin
          grant <= enc_idx;
          cnt   <= '0;
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (done) state <= ST_IDLE;
          else      cnt   <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Gating with rst_n keeps an aborted transaction from acking in the reset cycle.
  assign busy = rst_n && (state == ST_BUSY);
  assign done = busy && (s_ack_i || (cnt == CNT_LAST));

  always_comb begin
    case (grant)
      RIB_M_JTAG: sel = '{m0_wr_en_i, m0_addr_i, m0_data_i};
      RIB_M_CORE: sel = '{m1_wr_en_i, m1_addr_i, m1_data_i};
      RIB_M_UART: sel = '{m2_wr_en_i, m2_addr_i, m2_data_i};
      default:    sel = '0;
    endcase
  end

  assign s_req_o   = busy;
  assign s_wr_en_o = busy & sel.wr_en;
  assign s_addr_o  = busy ? sel.addr : '0;
  assign s_data_o  = busy ? sel.data : '0;

  // A coincident slave ack beats the timeout.
  assign rdata = s_ack_i ? s_data_i : ERR_DATA;
  assign err_o = done && !s_ack_i;

  assign m0_ack_o  = done && (grant == RIB_M_JTAG);
  assign m1_ack_o  = done && (grant == RIB_M_CORE);
  assign m2_ack_o  = done && (grant == RIB_M_UART);
  assign m0_data_o = m0_ack_o ? rdata : '0;
  assign m1_data_o = m1_ack_o ? rdata : '0;
  assign m2_data_o = m2_ack_o ? rdata : '0;

  assign hold_o = m1_req_i & ~m1_ack_o;

endmodule

// File: tb/tb_rib_arbiter.sv
// Randomized + directed bench for rib_arbiter against a transaction-level reference model.
module tb_rib_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, wr;
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [31:0] s_data_i;
  logic        s_ack_i;

  logic [31:0] d0, d1, d2, s_addr_o, s_data_o;
  logic        a0, a1, a2, s_req_o, s_wr_en_o, hold_o, err_o;

  always #5 clk = ~clk;

  rib_arbiter #(.TIMEOUT(TO), .ERR_DATA(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(req[0]), .m0_wr_en_i(wr[0]), .m0_addr_i(addr[0]), .m0_data_i(wdat[0]),
    .m0_data_o(d0), .m0_ack_o(a0),
    .m1_req_i(req[1]), .m1_wr_en_i(wr[1]), .m1_addr_i(addr[1]), .m1_data_i(wdat[1]),
    .m1_data_o(d1), .m1_ack_o(a1),
    .m2_req_i(req[2]), .m2_wr_en_i(wr[2]), .m2_addr_i(addr[2]), .m2_data_i(wdat[2]),
    .m2_data_o(d2), .m2_ack_o(a2),
    .s_req_o(s_req_o), .s_wr_en_o(s_wr_en_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .hold_o(hold_o), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which master owns the bus and how many cycles it has waited.
  bit          m_busy = 0;
  int          m_owner = 0;
  int          m_waited = 0;
  bit [2:0]    obs_ack;
  logic [31:0] obs_d [3];
  bit          obs_err;

  task automatic check_now();
    bit          finish;
    bit [2:0]    eack;
    logic [31:0] ed [3];
    logic [31:0] got_d [3];
    bit          on;
    on     = (rst_n === 1'b1) && m_busy;
    finish = on && (s_ack_i || (m_waited + 1 == TO));
    for (int n = 0; n < 3; n++) begin
      eack[n] = finish && (m_owner == n);
      ed[n]   = eack[n] ? (s_ack_i ? s_data_i : 32'h0) : 32'h0;
    end
    got_d[0] = d0; got_d[1] = d1; got_d[2] = d2;
    chk("s_req",   s_req_o,   on);
    chk("s_wr_en", s_wr_en_o, on ? wr[m_owner] : 1'b0);
    chk("s_addr",  s_addr_o,  on ? addr[m_owner] : 32'h0);
    chk("s_data",  s_data_o,  on ? wdat[m_owner] : 32'h0);
    chk("acks",    {a2, a1, a0}, eack);
    for (int n = 0; n < 3; n++) chk($sformatf("m%0d_data", n), got_d[n], ed[n]);
    chk("err",  err_o,  finish && !s_ack_i);
    chk("hold", hold_o, req[1] & ~eack[1]);
    obs_ack = {a2, a1, a0};
    obs_d   = got_d;
    obs_err = err_o;
  endtask

  task automatic model_edge();
    bit finish;
    finish = m_busy && (s_ack_i || (m_waited + 1 == TO));
    if (!rst_n) begin
      m_busy = 0; m_waited = 0;
    end else if (m_busy) begin
      if (finish) m_busy = 0;
      else        m_waited++;
    end else if (req != 3'b000) begin
      m_owner  = req[0] ? 0 : (req[1] ? 1 : 2);
      m_busy   = 1;
      m_waited = 0;
    end
  endtask

  // Inputs are set just after a negedge; check, then advance model at posedge.
  task automatic cycle();
    #1 check_now();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Serve master n: slave acks on the ack_at-th busy cycle (0 = never); optionally raise another master.
  task automatic run_txn(input int n, input int ack_at, input logic [31:0] sd, input int raise,
                         output logic [31:0] got_d, output bit got_err, output int nbusy);
    bit seen;
    seen = 0; nbusy = 0; got_d = 'x; got_err = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (s_req_o) nbusy++;
      if (raise >= 0 && nbusy == 2) req[raise] = 1'b1;
      s_ack_i  = (ack_at != 0) && s_req_o && (nbusy == ack_at);
      s_data_i = sd;
      cycle();
      if (obs_ack[n]) begin
        seen = 1; got_d = obs_d[n]; got_err = obs_err;
      end
    end
    chk($sformatf("m%0d_acked", n), seen, 1'b1);
    req[n]  = 1'b0;
    s_ack_i = 1'b0;
  endtask

  logic [31:0] gd;
  bit          ge;
  int          nb;

  initial begin
    rst_n = 1'b0; req = '0; wr = '0; s_ack_i = 0; s_data_i = 0;
    for (int n = 0; n < 3; n++) begin addr[n] = 0; wdat[n] = 0; end
    @(negedge clk);
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();

    // Core read, slave answers on the 4th request cycle
    req[1] = 1; wr[1] = 0; addr[1] = 32'h1000_0004;
    run_txn(1, 4, 32'hCAFE_0001, -1, gd, ge, nb);
    chk("rd_busy_cycles", nb, 4);
    chk("rd_data", gd, 32'hCAFE_0001);
    chk("rd_err", ge, 1'b0);
    cycle();

    // Contention m1 vs m2
    req[1] = 1; wr[1] = 1; addr[1] = 32'h2000_0000; wdat[1] = 32'h55;
    req[2] = 1; wr[2] = 0; addr[2] = 32'h3000_0010;
    run_txn(1, 2, 32'h0, -1, gd, ge, nb);
    chk("cont_m1_first_busy", nb, 2);
    chk("cont_idle_between", s_req_o, 1'b0);
    run_txn(2, 1, 32'hA5A5_0002, -1, gd, ge, nb);
    chk("cont_m2_data", gd, 32'hA5A5_0002);
    cycle();

    // Locked grant: m0 raised while m2 busy, served next
    req[2] = 1; addr[2] = 32'h3000_0020;
    run_txn(2, 5, 32'h0000_0222, 0, gd, ge, nb);
    chk("lock_m2_busy", nb, 5);
    chk("lock_m2_data", gd, 32'h0000_0222);
    wr[0] = 0; addr[0] = 32'h4000_0000;
    run_txn(0, 1, 32'h0000_0111, -1, gd, ge, nb);
    chk("lock_m0_next", gd, 32'h0000_0111);
    cycle();

    // Timeout: no slave ack
    req[0] = 1; addr[0] = 32'h5000_0000;
    run_txn(0, 0, 32'hDEAD_BEEF, -1, gd, ge, nb);
    chk("to_busy_cycles", nb, TO);
    chk("to_data", gd, 32'h0);
    chk("to_err", ge, 1'b1);
    cycle();

    // Ack on the last permitted cycle beats the timeout
    req[0] = 1;
    run_txn(0, TO, 32'h0000_1234, -1, gd, ge, nb);
    chk("tie_data", gd, 32'h0000_1234);
    chk("tie_err", ge, 1'b0);
    cycle();

    // Reset mid-transaction, ack offered during reset must be dropped
    req[1] = 1; addr[1] = 32'h1000_0100; wr[1] = 0;
    cycle(); cycle();
    rst_n = 0; s_ack_i = 1; s_data_i = 32'h7777_7777;
    cycle();
    chk("rst_no_ack", obs_ack, 3'b000);
    rst_n = 1; s_ack_i = 0;
    #1 chk("rst_sreq_low", s_req_o, 1'b0);
    run_txn(1, 2, 32'h0BAD_F00D, -1, gd, ge, nb);
    chk("post_rst_data", gd, 32'h0BAD_F00D);
    cycle();

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      bit quiet;
      quiet = (c % 600) < 40;
      for (int n = 0; n < 3; n++) begin
        if (obs_ack[n] || (req[n] && $urandom_range(0, 299) == 0))
          req[n] = 1'b0;
        if (!req[n] && $urandom_range(0, 3) == 0) begin
          req[n] = 1'b1; wr[n] = 1'($urandom); addr[n] = $urandom; wdat[n] = $urandom;
        end
      end
      s_ack_i  = !quiet && ($urandom_range(0, 3) == 0);
      s_data_i = $urandom;
      rst_n    = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
